// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock generator: per-channel period, high time and start phase.
// Optional macro CLKGEN_SHADOW_EN re-samples period/high_cnt at each period boundary while running.
module clk_div_gen #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*CNT_W-1:0] period,
  input  logic [NUM_CH*CNT_W-1:0] high_cnt,
  input  logic [NUM_CH*CNT_W-1:0] phase,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       cfg_err
);

  typedef enum logic [1:0] {IDLE, DELAY, RUN, DRAIN} state_t;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] per_in, hi_in, ph_in;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, dcnt_q, dcnt_d;
    logic [CNT_W-1:0] per_q, per_d, high_q, high_d;
    logic             clk_q, clk_d, err_q, err_d;
    logic             in_valid, last;

    assign per_in = period[ch*CNT_W +: CNT_W];
    assign hi_in  = high_cnt[ch*CNT_W +: CNT_W];
    assign ph_in  = phase[ch*CNT_W +: CNT_W];

    // high <= period-1 expressed as high < period to avoid wrap at period=0
    assign in_valid = (per_in >= CNT_W'(2)) && (hi_in != '0) && (hi_in < per_in);
    assign last     = (cnt_q == per_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        dcnt_q  <= '0;
        per_q   <= '0;
        high_q  <= '0;
        clk_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        dcnt_q  <= dcnt_d;
        per_q   <= per_d;
        high_q  <= high_d;
        clk_q   <= clk_d;
        err_q   <= err_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dcnt_d  = dcnt_q;
      per_d   = per_q;
      high_d  = high_q;
      clk_d   = 1'b0;
      err_d   = err_q;
      case (state_q)
        IDLE: begin
          if (enable[ch]) begin
            if (in_valid) begin
              per_d  = per_in;
              high_d = hi_in;
              err_d  = 1'b0;
              cnt_d  = '0;
              if (ph_in != '0) begin
                state_d = DELAY;
                dcnt_d  = ph_in;
              end else begin
                state_d = RUN;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
        DELAY: begin
          if (!enable[ch]) begin
            state_d = IDLE;
            dcnt_d  = '0;
          end else if (dcnt_q == CNT_W'(1)) begin
            state_d = RUN;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q - CNT_W'(1);
          end
        end
        RUN, DRAIN: begin
          // clk_q shows the cnt value held during the previous cycle
          clk_d = (cnt_q < high_q);
          cnt_d = last ? '0 : cnt_q + CNT_W'(1);
          if (enable[ch]) begin
            state_d = RUN;
          end else if (last) begin
            state_d = IDLE;
            clk_d   = 1'b0;
          end else begin
            state_d = DRAIN;
          end
`ifdef CLKGEN_SHADOW_EN
          if (last) begin
            if (in_valid) begin
              per_d  = per_in;
              high_d = hi_in;
            end else begin
              err_d = 1'b1;
            end
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end

    assign clk_out[ch] = clk_q;
    assign busy[ch]    = (state_q != IDLE);
    assign cfg_err[ch] = err_q;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: an age/modulo waveform model predicts every cycle,
// a monitor compares; directed scenarios followed by random enable/config traffic.
module tb_clk_div_gen;
  localparam int NC = 2;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC-1:0]   enable;
  logic [NC*W-1:0] period, high_cnt, phase;
  logic [NC-1:0]   clk_out, busy, cfg_err;

  clk_div_gen #(.NUM_CH(NC), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
    .high_cnt(high_cnt), .phase(phase), .clk_out(clk_out), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0] o;
    logic [NC-1:0] b;
    logic [NC-1:0] e;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_x, mon_x;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic bit cfg_ok(input int p, input int h);
    return (p >= 2) && (h >= 1) && (h <= p - 1);
  endfunction

  // Model: k = edges since the start sample; waveform position r = k - base within a period.
  bit m_act[NC];
  bit m_err[NC];
  int m_k[NC], m_ph[NC], m_per[NC], m_hi[NC], m_base[NC];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) begin
        m_act[c] = 1'b0;
        m_err[c] = 1'b0;
      end
      exp_q.delete();
    end else begin
      m_x = '0;
      for (int c = 0; c < NC; c++) begin
        int  p, h, r;
        bit  en, lst;
        en = enable[c];
        p  = int'(period[c*W +: W]);
        h  = int'(high_cnt[c*W +: W]);
        if (!m_act[c]) begin
          if (en) begin
            if (cfg_ok(p, h)) begin
              m_act[c]  = 1'b1;
              m_k[c]    = 0;
              m_ph[c]   = int'(phase[c*W +: W]);
              m_per[c]  = p;
              m_hi[c]   = h;
              m_base[c] = m_ph[c] + 1;
              m_err[c]  = 1'b0;
              m_x.b[c]  = 1'b1;
            end else begin
              m_err[c] = 1'b1;
            end
          end
        end else begin
          m_k[c]++;
          if (m_k[c] <= m_ph[c]) begin
            if (!en) m_act[c] = 1'b0;
            else     m_x.b[c] = 1'b1;
          end else begin
            r   = m_k[c] - m_base[c];
            m_x.o[c] = (r < m_hi[c]);
            lst = (r == m_per[c] - 1);
`ifdef CLKGEN_SHADOW_EN
            if (lst) begin
              if (cfg_ok(p, h)) begin
                m_per[c] = p;
                m_hi[c]  = h;
              end else begin
                m_err[c] = 1'b1;
              end
            end
`endif
            if (lst && !en) begin
              m_act[c] = 1'b0;
              m_x.o[c] = 1'b0;
            end else begin
              m_x.b[c] = 1'b1;
              if (lst) m_base[c] = m_k[c] + 1;
            end
          end
        end
        m_x.e[c] = m_err[c];
      end
      exp_q.push_back(m_x);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      check("clk_out", clk_out, mon_x.o);
      check("busy", busy, mon_x.b);
      check("cfg_err", cfg_err, mon_x.e);
    end
  end

  task automatic set_ch(input int c, input logic en, input int p, input int h, input int ph);
    enable[c]           = en;
    period[c*W +: W]    = p[W-1:0];
    high_cnt[c*W +: W]  = h[W-1:0];
    phase[c*W +: W]     = ph[W-1:0];
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p, h, ph;
    bit seen;
    rst_n = 1'b0; enable = '0; period = '0; high_cnt = '0; phase = '0;
    cyc(3);
    check("reset_clk_out", clk_out, '0);
    check("reset_busy", busy, '0);
    check("reset_cfg_err", cfg_err, '0);
    rst_n = 1'b1;

    // 4/2/0: 1100 repeating
    set_ch(0, 1, 4, 2, 0); cyc(12);
    enable[0] = 1'b0;      cyc(6);
    // 5/1/3: delayed start then 10000
    set_ch(0, 1, 5, 1, 3); cyc(16);
    enable[0] = 1'b0;      cyc(8);
    // 8/4/0: drop at cnt=1, then drop and re-enable inside DRAIN
    set_ch(0, 1, 8, 4, 0); cyc(2);
    enable[0] = 1'b0;      cyc(12);
    enable[0] = 1'b1;      cyc(3);
    enable[0] = 1'b0;      cyc(2);
    enable[0] = 1'b1;      cyc(10);
    enable[0] = 1'b0;      cyc(12);

    // invalid configurations
    for (int i = 0; i < 3; i++) begin
      p = (i == 0) ? 1 : 4;
      h = (i == 2) ? 4 : 0;
      set_ch(0, 1, p, h, 0); cyc(2);
      check("invalid_cfg_err", {1'b0, cfg_err[0]}, 2'b01);
      check("invalid_clk_out", {1'b0, clk_out[0]}, 2'b00);
      enable[0] = 1'b0; cyc(1);
    end
    set_ch(0, 1, 4, 2, 0); cyc(2);
    check("valid_clears_err", {1'b0, cfg_err[0]}, 2'b00);
    enable[0] = 1'b0; cyc(6);

    // two channels, asynchronous reset while ch0 is high
    set_ch(0, 1, 4, 2, 0);
    set_ch(1, 1, 6, 3, 2);
    cyc(7);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (clk_out[0]) seen = 1'b1;
      else cyc(1);
    end
    check("wait_ch0_high", {1'b0, seen}, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("async_clk_out", clk_out, '0);
    check("async_busy", busy, '0);
    check("async_cfg_err", cfg_err, '0);
    enable = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // period changed 4->6 mid-period
    set_ch(0, 1, 4, 2, 0); cyc(2);
    period[0 +: W] = 8'd6; cyc(20);
    enable[0] = 1'b0;      cyc(10);

    // random traffic
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 9) == 0) enable[c] = ~enable[c];
        if ($urandom_range(0, 7) == 0) begin
          p  = $urandom_range(1, 10);
          h  = $urandom_range(0, p);
          ph = $urandom_range(0, 4);
          set_ch(c, enable[c], p, h, ph);
        end
      end
      cyc(1);
    end
    enable = '0;
    cyc(15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
